// File: rtl/addsub_accumulator_pkg.sv
// Shared types, widths and helpers for the add/sub accumulator stage.
// Holds FSM encoding, operand modes and the signed-overflow rule.
package addsub_accumulator_pkg;

    localparam int DATA_W = 16;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    // Signed overflow of a +/- b giving s.
    function automatic logic ovf_of(
        input logic              mode,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] s
    );
        logic w_same;
        logic w_flip;
        w_same = (a[DATA_W-1] == b[DATA_W-1]);
        w_flip = (s[DATA_W-1] != a[DATA_W-1]);
        if (mode == MODE_ADD)
            return w_same && w_flip;
        else
            return !w_same && w_flip;
    endfunction

endpackage

// File: rtl/addsub_accumulator_if.sv
// Operand-in and result-out valid/ready streams of the accumulator.
// master = producer/consumer side, slave = the accumulator stage.
import addsub_accumulator_pkg::*;

interface addsub_accumulator_if #(
    parameter int CNT_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_mode;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sum;
    logic              out_cout;
    logic              out_ovf;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_valid, in_data, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf,
        input  out_count
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf,
        output out_count
    );
endinterface

// File: rtl/addsub_accumulator_sub_adder.sv
// 16-bit adder/subtractor: sum = a + b or a - b (two's complement).
// For subtract, cout = 1 means no borrow.
import addsub_accumulator_pkg::*;

module Sub_adder_16bit (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_mode,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_cout
);
    logic [DATA_W-1:0] w_b;
    logic [DATA_W:0]   w_full;

    assign w_b    = (i_mode == MODE_SUB) ? ~i_b : i_b;
    assign w_full = {1'b0, i_a} + {1'b0, w_b}
                  + {{DATA_W{1'b0}}, i_mode};
    assign o_sum  = w_full[DATA_W-1:0];
    assign o_cout = w_full[DATA_W];
endmodule

// File: rtl/addsub_accumulator.sv
// Frame accumulator: folds a stream of +/- operands into one result
// with carry, sticky signed overflow and a saturating beat count.
import addsub_accumulator_pkg::*;

module addsub_accumulator #(
    parameter int CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    addsub_accumulator_if.slave bus
);
    state_t            r_state;
    logic [DATA_W-1:0] r_acc;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_out_sum;
    logic              r_out_cout;
    logic              r_out_ovf;
    logic [CNT_W-1:0]  r_out_count;

    logic [DATA_W-1:0] w_sum;
    logic              w_cout;
    logic              w_v;
    logic              w_fire;
    logic [CNT_W-1:0]  w_cnt_nxt;

    Sub_adder_16bit u_adder (
        .i_a    (r_acc),
        .i_b    (bus.in_data),
        .i_mode (bus.in_mode),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_v       = ovf_of(bus.in_mode, r_acc, bus.in_data, w_sum);
    assign w_fire    = bus.in_valid && (r_state == ST_ACCUM);
    assign w_cnt_nxt = (r_count == {CNT_W{1'b1}})
                     ? r_count : r_count + 1'b1;

    assign bus.in_ready  = (r_state == ST_ACCUM);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_sum   = r_out_sum;
    assign bus.out_cout  = r_out_cout;
    assign bus.out_ovf   = r_out_ovf;
    assign bus.out_count = r_out_count;

    // FSM: accumulate beats, latch result on last, hold until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_count     <= '0;
            r_out_sum   <= '0;
            r_out_cout  <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_count <= '0;
        end else begin
            unique case (r_state)
                ST_ACCUM: begin
                    if (w_fire) begin
                        if (bus.in_last) begin
                            r_out_sum   <= w_sum;
                            r_out_cout  <= w_cout;
                            r_out_ovf   <= r_ovf | w_v;
                            r_out_count <= w_cnt_nxt;
                            r_state     <= ST_DONE;
                            r_acc       <= '0;
                            r_ovf       <= 1'b0;
                            r_count     <= '0;
                        end else begin
                            r_acc   <= w_sum;
                            r_ovf   <= r_ovf | w_v;
                            r_count <= w_cnt_nxt;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready)
                        r_state <= ST_ACCUM;
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end
endmodule
